// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: op encodings,
// FSM state type and the iteration-counter width helper.
package div_pkg;

    // Operation encodings as presented on the op port.
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_e;

    // Width of the iteration counter for an n-bit divider.
    function automatic int div_cnt_width(input int n);
        return $clog2(n);
    endfunction

    // Counter width for the default 32-bit configuration.
    localparam int DIV_CNT_W = $clog2(32);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the
// partial remainder and keep the difference only when it does not borrow.
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] partial,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] trial;

    // N+1-bit subtract so the borrow lands in the top bit and alone decides the quotient bit.
    always_comb begin
        trial    = {1'b0, partial} - {1'b0, divisor};
        q_bit    = ~trial[N];
        rem_next = trial[N] ? partial : trial[N-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock in CALC, sign correction in FIX; divide-by-zero
// and signed overflow are resolved without iterating.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int           CW       = div_cnt_width(N);
    localparam logic [N-1:0] ONE      = N'(1);
    localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] LAST_IT = CW'(N - 1);

    div_state_e    state;
    logic [N-1:0]  q;
    logic [N-1:0]  rem;
    logic [N-1:0]  dsr;
    logic [CW-1:0] cnt;
    logic          sign_q;
    logic          sign_r;
    logic          is_rem;
    logic          spec_pend;
    logic [N-1:0]  spec_val;

    logic          is_signed;
    logic          is_rem_op;
    logic          div_zero;
    logic          sgn_ovf;
    logic          special;
    logic [N-1:0]  spec_res;
    logic [N-1:0]  dvd_abs;
    logic [N-1:0]  dsr_abs;
    logic [N-1:0]  partial;
    logic [N-1:0]  step_rem;
    logic          step_bit;
    logic [N-1:0]  q_fix;
    logic [N-1:0]  rem_fix;

    // Decode the incoming request, special cases, operand magnitudes and final sign fix-ups.
    always_comb begin
        is_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
        is_rem_op = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
        div_zero  = (divisor == '0);
        sgn_ovf   = is_signed && (dividend == MIN_NEG) && (divisor == '1);
        special   = div_zero || sgn_ovf;
        spec_res  = '0;
        if (div_zero) begin
            spec_res = is_rem_op ? dividend : '1;
        end else begin
            spec_res = is_rem_op ? '0 : dividend;
        end
        dvd_abs = (is_signed && dividend[N-1]) ? (~dividend + ONE) : dividend;
        dsr_abs = (is_signed && divisor[N-1])  ? (~divisor + ONE)  : divisor;
        partial = {rem[N-2:0], q[N-1]};
        q_fix   = sign_q ? (~q + ONE) : q;
        rem_fix = sign_r ? (~rem + ONE) : rem;
    end

    div_step #(
        .N(N)
    ) u_step (
        .partial  (partial),
        .divisor  (dsr),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    // Control FSM plus datapath registers; q starts as the dividend and shifts left as quotient bits arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            q         <= '0;
            rem       <= '0;
            dsr       <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            is_rem    <= 1'b0;
            spec_pend <= 1'b0;
            spec_val  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A special-case answer decided last edge is published now; a new start may overlap it.
                    if (spec_pend) begin
                        result    <= spec_val;
                        done      <= 1'b1;
                        spec_pend <= 1'b0;
                    end
                    if (start) begin
                        is_rem <= is_rem_op;
                        if (special) begin
                            spec_pend <= 1'b1;
                            spec_val  <= spec_res;
                        end else begin
                            state  <= CALC;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            q      <= dvd_abs;
                            rem    <= '0;
                            dsr    <= dsr_abs;
                            sign_q <= is_signed && (dividend[N-1] ^ divisor[N-1]);
                            sign_r <= is_signed && dividend[N-1];
                        end
                    end
                end
                CALC: begin
                    q   <= {q[N-2:0], step_bit};
                    rem <= step_rem;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_IT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= is_rem ? rem_fix : q_fix;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=32): directed cases with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model built on plain integer division.
module tb_seq_divider;
    import div_pkg::*;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [N-1:0]  dividend = '0;
    logic [N-1:0]  divisor = '0;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;

    int n_checks = 0;
    int n_fail = 0;

    seq_divider #(
        .N(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic bit op_signed(input logic [1:0] o);
        return (o == DIV_OP_DIV) || (o == DIV_OP_REM);
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (op_signed(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        if (b == 32'h0)
            return (o == DIV_OP_DIV || o == DIV_OP_DIVU) ? 32'hFFFF_FFFF : a;
        if (op_signed(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (o == DIV_OP_DIV) ? a : 32'h0;
        case (o)
            DIV_OP_DIV:  return 32'(ia / ib);
            DIV_OP_REM:  return 32'(ia % ib);
            DIV_OP_DIVU: return a / b;
            default:     return a % b;
        endcase
    endfunction

    // ---------------- transaction model ----------------
    typedef struct {
        int          due;
        logic [31:0] val;
    } pend_t;

    pend_t       pend[$];
    int          cyc = 0;
    int          m_busy_end = -1;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_result = '0;

    // Each accepted request is due 1 edge (special) or N+1 edges later; the unit is idle once past the last due edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pend.delete();
                m_busy_end = -1;
                m_busy     = 1'b0;
                m_done     = 1'b0;
                m_result   = '0;
            end else begin
                pend_t p;
                cyc++;
                m_done = 1'b0;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    m_done   = 1'b1;
                    m_result = pend[0].val;
                    void'(pend.pop_front());
                end
                if (start && cyc > m_busy_end) begin
                    p.val = ref_div(op, dividend, divisor);
                    if (is_special(op, dividend, divisor)) begin
                        p.due = cyc + 1;
                    end else begin
                        p.due      = cyc + N + 1;
                        m_busy_end = p.due;
                    end
                    pend.push_back(p);
                end
                m_busy = (cyc < m_busy_end);
            end
        end
    end

    // Per-cycle comparison against the model, plus result hold between done pulses.
    logic [31:0] prev_result = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("done", 32'(done), 32'(m_done));
                chk("busy", 32'(busy), 32'(m_busy));
                chk("result", result, m_result);
                if (!done) chk("result_hold", result, prev_result);
            end
            prev_result = result;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output bit found, output int lat, output int bc);
        found = 1'b0;
        lat   = 0;
        bc    = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        bit found;
        int lat;
        int bc;
        chk({name, "_model"}, ref_div(o, a, b), exp);
        @(negedge clk);
        drive(o, a, b);
        wait_done(found, lat, bc);
        chk({name, "_seen"}, 32'(found), 32'd1);
        chk({name, "_result"}, result, exp);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy_cycles"}, 32'(bc), (exp_lat == 1) ? 32'd0 : 32'(exp_lat));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom % 8)
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom % 16);
            4:       return 32'h1;
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        int lat;
        int bc;

        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal operations: N+1 edges of latency.
        run_check("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, N + 1);
        run_check("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, N + 1);
        run_check("div_m100_7", DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, N + 1);
        run_check("rem_m100_7", DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, N + 1);
        run_check("rem_100_m7", DIV_OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, N + 1);

        // Special cases: one edge of latency, busy never asserted.
        run_check("div_5_0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_check("remu_5_0", DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_check("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_check("rem_ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // start mid-CALC with other operands is ignored.
        @(negedge clk);
        drive(DIV_OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        op       = DIV_OP_REMU;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(found, lat, bc);
        chk("ignore_start_seen", 32'(found), 32'd1);
        chk("ignore_start_result", result, 32'd14);

        // start held in the done cycle is accepted and completes N+1 edges later.
        @(negedge clk);
        drive(DIV_OP_DIVU, 32'd1000, 32'd3);
        wait_done(found, lat, bc);
        chk("b2b_first_result", result, 32'd333);
        drive(DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7);
        wait_done(found, lat, bc);
        chk("b2b_second_seen", 32'(found), 32'd1);
        chk("b2b_second_result", result, 32'hFFFF_FFF2);
        chk("b2b_second_latency", 32'(lat), 32'(N + 1));

        // Reset in the middle of an iteration.
        @(negedge clk);
        drive(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_result", result, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("midreset_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            chk("abandoned_no_done", 32'(done), 32'd0);
        end
        run_check("divu_max_1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, N + 1);

        // Randomized traffic, including starts while busy and in done cycles.
        for (int i = 0; i < 45000; i++) begin
            @(negedge clk);
            start    = ($urandom % 3 == 0);
            op       = 2'($urandom % 4);
            dividend = rnd_val();
            divisor  = rnd_val();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
